// File: rtl/sad_buffer_fill_ctrl.sv
// SAD reference-buffer fill controller: turns load-buffer requests into data-memory
// read bursts and streams the returned words into buffer A (window) or B (frame).
module sad_buffer_fill_ctrl #(
    parameter int unsigned WORDS_A = 4,
    parameter int unsigned WORDS_B = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [31:0]      addr_a,
    input  logic [31:0]      addr_b,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             buf_we,
    output logic             buf_sel,
    output logic [IDX_W-1:0] buf_idx,
    output logic [31:0]      buf_wdata,
    output logic             all_buf_flags,
    output logic             ovf_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL_A = 2'd1;
    localparam logic [1:0] S_FILL_B = 2'd2;

    localparam logic [IDX_W-1:0] LAST_A = IDX_W'(WORDS_A - 1);
    localparam logic [IDX_W-1:0] LAST_B = IDX_W'(WORDS_B - 1);

    logic [1:0]       r_state;
    logic [31:0]      r_base;
    logic [IDX_W-1:0] r_idx;
    logic             r_pend_a;
    logic             r_pend_b;
    logic [31:0]      r_paddr_a;
    logic [31:0]      r_paddr_b;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic             r_buf_we;
    logic             r_buf_sel;
    logic [IDX_W-1:0] r_buf_idx;
    logic [31:0]      r_buf_wdata;
    logic             r_ovf;

    logic [1:0]       w_state_nx;
    logic [31:0]      w_base_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic             w_pend_a_nx;
    logic             w_pend_b_nx;
    logic [31:0]      w_paddr_a_nx;
    logic [31:0]      w_paddr_b_nx;
    logic             w_buf_we_nx;
    logic             w_buf_sel_nx;
    logic [IDX_W-1:0] w_buf_idx_nx;
    logic [31:0]      w_buf_wdata_nx;
    logic             w_ovf_nx;
    logic             w_take_a;
    logic             w_take_b;
    logic             w_start_a;
    logic             w_start_b;
    logic [31:0]      w_addr_a_al;
    logic [31:0]      w_addr_b_al;

    assign w_addr_a_al = addr_a & ~32'h3;
    assign w_addr_b_al = addr_b & ~32'h3;

    // Next-state, pending-slot and buffer-write logic
    always_comb begin
        w_state_nx     = r_state;
        w_base_nx      = r_base;
        w_idx_nx       = r_idx;
        w_pend_a_nx    = r_pend_a;
        w_pend_b_nx    = r_pend_b;
        w_paddr_a_nx   = r_paddr_a;
        w_paddr_b_nx   = r_paddr_b;
        w_buf_we_nx    = 1'b0;
        w_buf_sel_nx   = r_buf_sel;
        w_buf_idx_nx   = r_buf_idx;
        w_buf_wdata_nx = r_buf_wdata;
        w_ovf_nx       = r_ovf;
        w_take_a       = 1'b0;
        w_take_b       = 1'b0;
        w_start_a      = 1'b0;
        w_start_b      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pend_a || req_a) begin
                    w_state_nx = S_FILL_A;
                    w_idx_nx   = '0;
                    if (r_pend_a) begin
                        w_base_nx = r_paddr_a;
                        w_take_a  = 1'b1;
                    end else begin
                        w_base_nx = w_addr_a_al;
                        w_start_a = 1'b1;
                    end
                end else if (r_pend_b || req_b) begin
                    w_state_nx = S_FILL_B;
                    w_idx_nx   = '0;
                    if (r_pend_b) begin
                        w_base_nx = r_paddr_b;
                        w_take_b  = 1'b1;
                    end else begin
                        w_base_nx = w_addr_b_al;
                        w_start_b = 1'b1;
                    end
                end
            end
            S_FILL_A: begin
                if (mem_ack) begin
                    w_buf_we_nx    = 1'b1;
                    w_buf_sel_nx   = 1'b0;
                    w_buf_idx_nx   = r_idx;
                    w_buf_wdata_nx = mem_rdata;
                    if (r_idx == LAST_A) begin
                        w_idx_nx = '0;
                        if (r_pend_b) begin
                            w_state_nx = S_FILL_B;
                            w_base_nx  = r_paddr_b;
                            w_take_b   = 1'b1;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
            end
            S_FILL_B: begin
                if (mem_ack) begin
                    w_buf_we_nx    = 1'b1;
                    w_buf_sel_nx   = 1'b1;
                    w_buf_idx_nx   = r_idx;
                    w_buf_wdata_nx = mem_rdata;
                    if (r_idx == LAST_B) begin
                        w_idx_nx = '0;
                        if (r_pend_a) begin
                            w_state_nx = S_FILL_A;
                            w_base_nx  = r_paddr_a;
                            w_take_a   = 1'b1;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
            end
        endcase

        // A slot consumed this cycle is free again for a same-cycle request
        if (w_take_a) w_pend_a_nx = 1'b0;
        if (w_take_b) w_pend_b_nx = 1'b0;
        if (req_a && !w_start_a) begin
            if (r_pend_a && !w_take_a) begin
                w_ovf_nx = 1'b1;
            end else begin
                w_pend_a_nx  = 1'b1;
                w_paddr_a_nx = w_addr_a_al;
            end
        end
        if (req_b && !w_start_b) begin
            if (r_pend_b && !w_take_b) begin
                w_ovf_nx = 1'b1;
            end else begin
                w_pend_b_nx  = 1'b1;
                w_paddr_b_nx = w_addr_b_al;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_idx       <= '0;
            r_pend_a    <= 1'b0;
            r_pend_b    <= 1'b0;
            r_paddr_a   <= '0;
            r_paddr_b   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_buf_we    <= 1'b0;
            r_buf_sel   <= 1'b0;
            r_buf_idx   <= '0;
            r_buf_wdata <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_base      <= w_base_nx;
            r_idx       <= w_idx_nx;
            r_pend_a    <= w_pend_a_nx;
            r_pend_b    <= w_pend_b_nx;
            r_paddr_a   <= w_paddr_a_nx;
            r_paddr_b   <= w_paddr_b_nx;
            r_mem_req   <= (w_state_nx != S_IDLE);
            r_mem_addr  <= w_base_nx + (32'(w_idx_nx) << 2);
            r_buf_we    <= w_buf_we_nx;
            r_buf_sel   <= w_buf_sel_nx;
            r_buf_idx   <= w_buf_idx_nx;
            r_buf_wdata <= w_buf_wdata_nx;
            r_ovf       <= w_ovf_nx;
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign buf_we        = r_buf_we;
    assign buf_sel       = r_buf_sel;
    assign buf_idx       = r_buf_idx;
    assign buf_wdata     = r_buf_wdata;
    assign ovf_err       = r_ovf;
    // Decode stall: the live request terms make a back-to-back load wait
    assign all_buf_flags = (r_state == S_IDLE) & ~r_pend_a & ~r_pend_b & ~req_a & ~req_b;

endmodule
